// File: rtl/debounced_edge_pulse_generator.sv
// Debounced edge pulse generator: synchronizes a raw level, qualifies it for
// STABLE_CYCLES consecutive cycles, and emits one-cycle set/reset pulses.
module debounced_edge_pulse_generator #(
    parameter int unsigned SYNCHRONIZER_STAGES = 2,
    parameter int unsigned STABLE_CYCLES       = 4,
    parameter logic        RESET_VALUE         = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic data_in,
    output logic filtered,
    output logic rising_pulse,
    output logic falling_pulse,
    output logic busy
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(STABLE_CYCLES - 1);

    logic [SYNCHRONIZER_STAGES-1:0] r_sync;
    logic [CW-1:0]                  r_count;
    logic                           r_filtered;
    logic                           r_rise;
    logic                           r_fall;

    logic          w_synced;
    logic          w_holdoff;
    logic [CW-1:0] w_count_next;
    logic          w_filtered_next;
    logic          w_rise_next;
    logic          w_fall_next;

    assign w_synced  = r_sync[SYNCHRONIZER_STAGES-1];
    // A pulse in the previous cycle blocks acceptance; only reachable when
    // STABLE_CYCLES == 1, and keeps pulses from landing on consecutive cycles.
    assign w_holdoff = r_rise | r_fall;

    always_comb begin
        w_count_next    = '0;
        w_filtered_next = r_filtered;
        w_rise_next     = 1'b0;
        w_fall_next     = 1'b0;
        if (enable && (w_synced != r_filtered)) begin
            if (r_count == TERMINAL) begin
                if (!w_holdoff) begin
                    w_filtered_next = w_synced;
                    w_rise_next     = w_synced;
                    w_fall_next     = ~w_synced;
                end else begin
                    w_count_next = r_count;
                end
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_sync     <= {SYNCHRONIZER_STAGES{RESET_VALUE}};
            r_count    <= '0;
            r_filtered <= RESET_VALUE;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNCHRONIZER_STAGES-2:0], data_in};
            r_count    <= w_count_next;
            r_filtered <= w_filtered_next;
            r_rise     <= w_rise_next;
            r_fall     <= w_fall_next;
        end
    end

    assign filtered      = r_filtered;
    assign rising_pulse  = r_rise;
    assign falling_pulse = r_fall;
    assign busy          = (r_count != '0);

endmodule

// File: tb/tb_debounced_edge_pulse_generator.sv
// Scoreboard bench for debounced_edge_pulse_generator: two configurations
// (2 stages/4 cycles and 3 stages/1 cycle) driven by shared stimulus.
module tb_debounced_edge_pulse_generator;

    localparam int MAXE = 4096;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    logic data_in = 1'b0;

    logic f0, r0, fa0, b0;
    logic f1, r1, fa1, b1;

    debounced_edge_pulse_generator #(
        .SYNCHRONIZER_STAGES(2),
        .STABLE_CYCLES(4),
        .RESET_VALUE(1'b0)
    ) u_dut0 (
        .clock(clock), .resetn(resetn), .enable(enable), .data_in(data_in),
        .filtered(f0), .rising_pulse(r0), .falling_pulse(fa0), .busy(b0)
    );

    debounced_edge_pulse_generator #(
        .SYNCHRONIZER_STAGES(3),
        .STABLE_CYCLES(1),
        .RESET_VALUE(1'b0)
    ) u_dut1 (
        .clock(clock), .resetn(resetn), .enable(enable), .data_in(data_in),
        .filtered(f1), .rising_pulse(r1), .falling_pulse(fa1), .busy(b1)
    );

    always #5 clock = ~clock;

    // Reference model: synced is data_in delayed by the stage count (or the
    // reset value if a reset fell inside that window); a level is accepted
    // once it has differed from filtered for STABLE_CYCLES enabled edges.
    bit din_h[MAXE];
    int edge_n = 0;
    int last_rst[2] = '{-1, -1};
    bit m_filt[2];
    int streak[2];
    bit lastp[2];

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic model_edge(input int i, input int st, input int sc, output logic [3:0] e);
        int src;
        bit s;
        bit rise, fall;
        rise = 1'b0;
        fall = 1'b0;
        if (!resetn) begin
            m_filt[i]   = 1'b0;
            streak[i]   = 0;
            lastp[i]    = 1'b0;
            last_rst[i] = edge_n;
        end else begin
            src = edge_n - st;
            if (src < 0 || last_rst[i] >= src) s = 1'b0;
            else s = din_h[src % MAXE];
            if (enable && s != m_filt[i]) begin
                streak[i]++;
                if (streak[i] >= sc && !lastp[i]) begin
                    rise      = s;
                    fall      = !s;
                    m_filt[i] = s;
                    streak[i] = 0;
                end else if (streak[i] > sc - 1) begin
                    streak[i] = sc - 1;
                end
            end else begin
                streak[i] = 0;
            end
            lastp[i] = rise | fall;
        end
        e = {m_filt[i], rise, fall, (streak[i] != 0)};
    endtask

    always @(posedge clock) begin
        logic [3:0] e0, e1;
        din_h[edge_n % MAXE] = data_in;
        model_edge(0, 2, 4, e0);
        model_edge(1, 3, 1, e1);
        exp_q.push_back({e0, e1});
        edge_n++;
    end

    // Monitor: every cycle the DUTs present a fresh registered output.
    always @(posedge clock) begin
        logic [7:0] e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({f0, r0, fa0, b0} !== e[7:4]) begin
                n_bad++;
                $display("FAIL cfg_2x4 cyc=%0d got f/r/fa/busy=%b required %b",
                         cyc, {f0, r0, fa0, b0}, e[7:4]);
            end
            n_cmp++;
            if ({f1, r1, fa1, b1} !== e[3:0]) begin
                n_bad++;
                $display("FAIL cfg_3x1 cyc=%0d got f/r/fa/busy=%b required %b",
                         cyc, {f1, r1, fa1, b1}, e[3:0]);
            end
        end
    end

    task automatic drive(input bit rn, input bit en, input bit d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            resetn  = rn;
            enable  = en;
            data_in = d;
        end
    endtask

    initial begin
        int len;
        bit lvl, en_r;
        // reset held, then idle low
        drive(0, 1, 0, 3);
        drive(1, 1, 0, 20);
        // clean rise then clean fall
        drive(1, 1, 1, 20);
        drive(1, 1, 0, 20);
        // 3-cycle excursion rejected, 4-cycle accepted
        drive(1, 1, 1, 3);
        drive(1, 1, 0, 10);
        drive(1, 1, 1, 4);
        drive(1, 1, 0, 15);
        // enable low freezes, then qualification restarts
        drive(1, 0, 1, 10);
        drive(1, 1, 1, 10);
        drive(1, 1, 0, 3);
        drive(1, 0, 0, 2);
        drive(1, 1, 0, 15);
        // reset during a fall qualification
        drive(1, 1, 1, 10);
        drive(1, 1, 0, 4);
        drive(0, 1, 1, 1);
        drive(1, 1, 1, 12);
        drive(1, 1, 0, 12);
        // single-cycle glitch
        drive(1, 1, 1, 1);
        drive(1, 1, 0, 12);
        // randomized segments
        for (int s = 0; s < 400; s++) begin
            lvl  = 1'($urandom_range(0, 1));
            en_r = ($urandom_range(0, 9) != 0);
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12))
                                               : int'($urandom_range(1, 5));
            if ($urandom_range(0, 39) == 0) drive(0, en_r, lvl, 1);
            drive(1, en_r, lvl, len);
        end
        drive(1, 1, 0, 10);
        @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
